// File: rtl/alu_1_slice.sv
// alu_1_slice: registered bit-slice ALU, eight functions selected by {s2,s1,s0}.
// Latency: 1 clock from sampled inputs to y/cn_1; there is no combinational path from inputs to outputs.
// Backpressure: none; gnd=1 (active-low enable) freezes the outputs, and rst_n=0 overrides it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (y=0, cn_1=0, zf=1)
//   a, b       WIDTH-bit operands
//   cn         carry-in; for subtract, 1 means no borrow
//   s2,s1,s0   function select; s2=0 selects the logic group, s2=1 the arithmetic group
//   gnd        active-low operation enable, tied to 0 in normal use
//   y          registered WIDTH-bit result
//   cn_1       registered carry-out (always 0 for logic functions)
//   zf         registered zero flag, present only when ALU_ZERO_FLAG_EN is defined
//
// Optional feature macro: ALU_ZERO_FLAG_EN adds the zf output.

module alu_1_slice #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cn,
  input  logic             s0,
  input  logic             s1,
  input  logic             s2,
  input  logic             gnd,
  output logic [WIDTH-1:0] y,
`ifdef ALU_ZERO_FLAG_EN
  output logic             cn_1,
  output logic             zf
`else
  output logic             cn_1
`endif
);

  logic [2:0]     sel;
  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] nb_ext;
  logic [WIDTH:0] cn_ext;
  logic [WIDTH:0] res;      // {carry, result} for the next edge

  assign sel    = {s2, s1, s0};
  assign a_ext  = {1'b0, a};
  assign b_ext  = {1'b0, b};
  // Subtract is a + ~b + cn; the inversion is confined to the WIDTH data bits
  // so the extra top bit still captures the true carry-out.
  assign nb_ext = {1'b0, ~b};
  assign cn_ext = {{WIDTH{1'b0}}, cn};

  always_comb begin
    res = '0;
    case (sel)
      3'b000:  res = {1'b0, a & b};
      3'b001:  res = {1'b0, a | b};
      3'b010:  res = {1'b0, ~a};
      3'b011:  res = {1'b0, a ^ b};
      3'b100:  res = a_ext + b_ext + cn_ext;
      3'b101:  res = a_ext + nb_ext + cn_ext;
      3'b110:  res = a_ext + cn_ext;
      3'b111:  res = {1'b0, ~(a ^ b)};
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y    <= '0;
      cn_1 <= 1'b0;
    end else if (!gnd) begin
      y    <= res[WIDTH-1:0];
      cn_1 <= res[WIDTH];
    end
  end

`ifdef ALU_ZERO_FLAG_EN
  // Flag follows the value y is about to take, so it stays aligned with y.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zf <= 1'b1;
    end else if (!gnd) begin
      zf <= (res[WIDTH-1:0] == '0);
    end
  end
`endif

endmodule

// File: tb/tb_alu_1_slice.sv
// tb_alu_1_slice: directed self-checking bench for alu_1_slice.
// Drives a WIDTH=1 instance and a WIDTH=8 instance that share the control inputs,
// and checks results against hand-computed truth tables and constants.

module tb_alu_1_slice;

  logic       clk;
  logic       rst_n;
  logic       cn, s0, s1, s2, gnd;
  logic       a1, b1;
  logic       y1, c1;
  logic [7:0] a8, b8;
  logic [7:0] y8;
  logic       c8;
`ifdef ALU_ZERO_FLAG_EN
  logic       zf1, zf8;
`endif

  int total = 0;
  int bad   = 0;

  // Truth tables indexed by {cn,b,a}, one byte per select value.
  logic [7:0] tbl_y [8];
  logic [7:0] tbl_c [8];

  alu_1_slice #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cn(cn),
    .s0(s0), .s1(s1), .s2(s2), .gnd(gnd), .y(y1),
`ifdef ALU_ZERO_FLAG_EN
    .cn_1(c1), .zf(zf1)
`else
    .cn_1(c1)
`endif
  );

  alu_1_slice #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cn(cn),
    .s0(s0), .s1(s1), .s2(s2), .gnd(gnd), .y(y8),
`ifdef ALU_ZERO_FLAG_EN
    .cn_1(c8), .zf(zf8)
`else
    .cn_1(c8)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_sel(input logic [2:0] s);
    {s2, s1, s0} = s;
  endtask

  initial begin
    logic [5:0] vec;
    logic [2:0] vs;
    logic [2:0] vi;
    logic       prev_y, prev_c;

    tbl_y[0] = 8'h88; tbl_c[0] = 8'h00;  // a & b
    tbl_y[1] = 8'hEE; tbl_c[1] = 8'h00;  // a | b
    tbl_y[2] = 8'h55; tbl_c[2] = 8'h00;  // ~a
    tbl_y[3] = 8'h66; tbl_c[3] = 8'h00;  // a ^ b
    tbl_y[4] = 8'h96; tbl_c[4] = 8'hE8;  // a + b + cn
    tbl_y[5] = 8'h69; tbl_c[5] = 8'hB2;  // a + ~b + cn
    tbl_y[6] = 8'h5A; tbl_c[6] = 8'hA0;  // a + cn
    tbl_y[7] = 8'h99; tbl_c[7] = 8'h00;  // ~(a ^ b)

    // Reset held for two edges with inputs that would otherwise give 1/1.
    rst_n = 1'b0; gnd = 1'b0; cn = 1'b1; set_sel(3'b100);
    a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    tick();
    tick();
    check1("rst_y1", y1, 1'b0);
    check1("rst_c1", c1, 1'b0);
    check8("rst_y8", y8, 8'h00);
    check1("rst_c8", c8, 1'b0);
`ifdef ALU_ZERO_FLAG_EN
    check1("rst_zf8", zf8, 1'b1);
`endif

    // Release: 1+1+1 -> y=1, cn_1=1; FF+FF+1 = 1FF.
    rst_n = 1'b1;
    tick();
    check1("rel_y1", y1, 1'b1);
    check1("rel_c1", c1, 1'b1);
    check8("rel_y8", y8, 8'hFF);
    check1("rel_c8", c8, 1'b1);

    // Exhaustive sweep of {s2,s1,s0,cn,b,a}; outputs must not move until the edge.
    prev_y = 1'b1;
    prev_c = 1'b1;
    for (int v = 0; v < 64; v++) begin
      vec = 6'(v);
      {s2, s1, s0, cn, b1, a1} = vec;
      vs = vec[5:3];
      vi = vec[2:0];
      #1;
      check1("sweep_hold_y", y1, prev_y);
      check1("sweep_hold_c", c1, prev_c);
      tick();
      prev_y = tbl_y[vs][vi];
      prev_c = tbl_c[vs][vi];
      check1("sweep_y", y1, prev_y);
      check1("sweep_c", c1, prev_c);
    end

    // Subtract at WIDTH=8.
    cn = 1'b1; set_sel(3'b101); a8 = 8'h05; b8 = 8'h03;
    tick();
    check8("sub_5m3_y", y8, 8'h02);
    check1("sub_5m3_c", c8, 1'b1);
`ifdef ALU_ZERO_FLAG_EN
    check1("sub_5m3_zf", zf8, 1'b0);
`endif
    a8 = 8'h03; b8 = 8'h05;
    tick();
    check8("sub_3m5_y", y8, 8'hFE);
    check1("sub_3m5_c", c8, 1'b0);

    // Increment wrap.
    set_sel(3'b110); a8 = 8'hFF; cn = 1'b1;
    tick();
    check8("inc_wrap_y", y8, 8'h00);
    check1("inc_wrap_c", c8, 1'b1);
`ifdef ALU_ZERO_FLAG_EN
    check1("inc_wrap_zf", zf8, 1'b1);
`endif

    // A few 8-bit logic and add patterns.
    set_sel(3'b000); a8 = 8'h3C; b8 = 8'h0F; cn = 1'b1;
    tick();
    check8("and8_y", y8, 8'h0C);
    check1("and8_c", c8, 1'b0);
    set_sel(3'b111);
    tick();
    check8("xnor8_y", y8, 8'hCC);
    set_sel(3'b100); a8 = 8'h80; b8 = 8'h80; cn = 1'b0;
    tick();
    check8("add8_y", y8, 8'h00);
    check1("add8_c", c8, 1'b1);

    // Hold: load via OR, then gnd=1 while inputs change for 3 cycles.
    set_sel(3'b001); a1 = 1'b1; b1 = 1'b0; a8 = 8'h5A; b8 = 8'h21; cn = 1'b0;
    tick();
    check1("load_y1", y1, 1'b1);
    check8("load_y8", y8, 8'h7B);
    gnd = 1'b1;
    set_sel(3'b000); a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    tick();
    check1("hold1_y1", y1, 1'b1);
    check1("hold1_c1", c1, 1'b0);
    check8("hold1_y8", y8, 8'h7B);
    set_sel(3'b100); a1 = 1'b1; b1 = 1'b1; cn = 1'b1; a8 = 8'hF0; b8 = 8'hF0;
    tick();
    check1("hold2_y1", y1, 1'b1);
    check1("hold2_c1", c1, 1'b0);
    check1("hold2_c8", c8, 1'b0);
    set_sel(3'b010); a1 = 1'b1; a8 = 8'h0F;
    tick();
    check1("hold3_y1", y1, 1'b1);
    check8("hold3_y8", y8, 8'h7B);
    gnd = 1'b0;
    tick();
    check1("resume_y1", y1, 1'b0);
    check1("resume_c1", c1, 1'b0);
    check8("resume_y8", y8, 8'hF0);

    // Reset while disabled with y=1.
    set_sel(3'b001); a1 = 1'b1; b1 = 1'b0;
    tick();
    check1("pre_rst_y1", y1, 1'b1);
    gnd = 1'b1; rst_n = 1'b0;
    tick();
    check1("mid_rst_y1", y1, 1'b0);
    check1("mid_rst_c1", c1, 1'b0);
`ifdef ALU_ZERO_FLAG_EN
    check1("mid_rst_zf1", zf1, 1'b1);
`endif
    rst_n = 1'b1;
    tick();
    check1("post_rst_hold_y1", y1, 1'b0);
    gnd = 1'b0;
    tick();
    check1("post_rst_run_y1", y1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
